// File: rtl/serial_word_transmitter.sv
// Parallel-in, serial-out word transmitter: one WIDTH-bit word per valid/ready handshake, sent MSB first.
// Optional even-parity trailer bit and par_out port when TX_PARITY_EN is defined.
module serial_word_transmitter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             tx_pause,
  output logic             ser_out,
  output logic             ser_en,
  output logic             busy,
`ifdef TX_PARITY_EN
  output logic             par_out,
`endif
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef TX_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [CNT_W-1:0] cnt, cnt_next;
`ifdef TX_PARITY_EN
  logic             par_reg, par_next;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      cnt     <= '0;
`ifdef TX_PARITY_EN
      par_reg <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      cnt     <= cnt_next;
`ifdef TX_PARITY_EN
      par_reg <= par_next;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
`ifdef TX_PARITY_EN
    par_next   = par_reg;
`endif
    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          shreg_next = tx_data;
          cnt_next   = CNT_W'(WIDTH);
`ifdef TX_PARITY_EN
          par_next   = ^tx_data;
`endif
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A paused cycle leaves the current bit on the line and the counter untouched
        if (!tx_pause) begin
          shreg_next = {shreg[WIDTH-2:0], 1'b0};
          cnt_next   = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
`ifdef TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_DONE;
`endif
          end
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: state_next = S_DONE;
`endif
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; ser_en also honours a same-cycle pause
  assign tx_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign ser_en   = (state == S_SHIFT) && !tx_pause;
`ifdef TX_PARITY_EN
  assign par_out  = (state == S_PARITY);
  assign ser_out  = (state == S_SHIFT)  ? shreg[WIDTH-1] :
                    (state == S_PARITY) ? par_reg : 1'b0;
`else
  assign ser_out  = (state == S_SHIFT) ? shreg[WIDTH-1] : 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Randomized bench for serial_word_transmitter: expected per-cycle line activity is derived from the
// word, the applied pause pattern and the bit-ordering rules; a bench-side receiver rebuilds the word.
module tb_serial_word_transmitter;

  localparam int unsigned W = 16;
`ifdef TX_PARITY_EN
  localparam int unsigned PAR_CYC = 1;
`else
  localparam int unsigned PAR_CYC = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_pause;
  logic         ser_out;
  logic         ser_en;
  logic         busy;
  logic         done;
`ifdef TX_PARITY_EN
  logic         par_out;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  serial_word_transmitter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_pause (tx_pause),
    .ser_out  (ser_out),
    .ser_en   (ser_en),
    .busy     (busy),
`ifdef TX_PARITY_EN
    .par_out  (par_out),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, 32'(tx_ready), 32'd1);
    check({tag, "_en"},    32'(ser_en),   32'd0);
    check({tag, "_out"},   32'(ser_out),  32'd0);
    check({tag, "_busy"},  32'(busy),     32'd0);
    check({tag, "_done"},  32'(done),     32'd0);
`ifdef TX_PARITY_EN
    check({tag, "_par"},   32'(par_out),  32'd0);
`endif
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      tx_valid = 1'b0;
      tx_pause = 1'($urandom);
      tx_data  = W'($urandom);
      @(negedge clk);
      check_quiet("idle");
    end
  endtask

  // Sends one word; p_lo..p_hi forces pause on those post-accept cycles, pct adds random pauses.
  // reset_at > 0 asserts reset on that post-accept cycle. done_k is the cycle done was seen (0 if none).
  task automatic send_word(input logic [W-1:0] w, input int pct, input int p_lo, input int p_hi,
                           input int reset_at, output int accept_cyc, output int done_k);
    logic [W-1:0] q;
    int  sent;
    int  k;
    bit  pz;
    bit  par_pending;
    q = '0; sent = 0; k = 0; done_k = 0;
    par_pending = (PAR_CYC != 0);
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = w;
    tx_pause = 1'($urandom);
    @(negedge clk);
    check_quiet("accept");
    accept_cyc = cyc;
    forever begin
      @(posedge clk); #1;
      k++;
      tx_valid = 1'($urandom);
      tx_data  = W'($urandom);
      pz = ((k >= p_lo) && (k <= p_hi)) || (($urandom_range(99)) < 32'(pct));
      tx_pause = pz;
      if (k == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        check_quiet("rst_mid");
        @(posedge clk); #1;
        reset    = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        check_quiet("rst_after");
        return;
      end
      @(negedge clk);
      if (k > 1000) begin
        check("cycle_budget", 32'(k), 32'd0);
        return;
      end
      if (sent < int'(W)) begin
        check("shift_en",    32'(ser_en),   32'(!pz));
        check("shift_bit",   32'(ser_out),  32'(w[W-1-sent]));
        check("shift_busy",  32'(busy),     32'd1);
        check("shift_ready", 32'(tx_ready), 32'd0);
        check("shift_done",  32'(done),     32'd0);
        if (ser_en) q = {q[W-2:0], ser_out};
        if (!pz) sent++;
      end else if (par_pending) begin
        par_pending = 1'b0;
        check("par_en",   32'(ser_en),  32'd0);
        check("par_bit",  32'(ser_out), 32'(^w));
        check("par_busy", 32'(busy),    32'd1);
        check("par_done", 32'(done),    32'd0);
`ifdef TX_PARITY_EN
        check("par_flag", 32'(par_out), 32'd1);
`endif
      end else begin
        check("done_pulse", 32'(done),     32'd1);
        check("done_en",    32'(ser_en),   32'd0);
        check("done_out",   32'(ser_out),  32'd0);
        check("done_busy",  32'(busy),     32'd1);
        check("done_ready", 32'(tx_ready), 32'd0);
        check("rx_word",    32'(q),        32'(w));
        done_k = k;
        return;
      end
    end
  endtask

  initial begin
    int a1, a2, dk;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_pause = 1'b0;
    tx_data  = '0;
    @(negedge clk);
    check_quiet("in_reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Quiet line with no producer
    idle_cycles(10);

    // Clean word: 16 data cycles then done
    send_word(16'hA5C3, 0, 0, -1, 0, a1, dk);
    check("t2_done_cycle", 32'(dk), 32'(W + 1 + PAR_CYC));
    idle_cycles(2);

    // Three paused cycles stretch the word by three
    send_word(16'h8001, 0, 3, 5, 0, a1, dk);
    check("t3_done_cycle", 32'(dk), 32'(W + 4 + PAR_CYC));

    // Back-to-back words with valid held through the idle cycle
    send_word(16'h1234, 0, 0, -1, 0, a1, dk);
    send_word(16'hFFFF, 0, 0, -1, 0, a2, dk);
    check("t4_spacing", 32'(a2 - a1), 32'(W + 2 + PAR_CYC));
    idle_cycles(1);

    // Reset mid-word, then a clean word
    send_word(16'h5A5A, 0, 0, -1, 7, a1, dk);
    check("t5_no_done", 32'(dk), 32'd0);
    send_word(16'h0F0F, 0, 0, -1, 0, a1, dk);
    send_word(16'h0001, 0, 0, -1, 0, a1, dk);
    check("t6_done_cycle", 32'(dk), 32'(W + 1 + PAR_CYC));

    // Random words, random pauses, random gaps
    for (int i = 0; i < 24; i++) begin
      send_word(W'($urandom), 25, 0, -1, 0, a1, dk);
      idle_cycles(int'($urandom_range(2)));
    end
    tx_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
